// File: rtl/riscv_pkg.sv
// Shared core definitions: data width, register-index width and handy typedefs.
// No ports; imported by the register file and its scoreboard.
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NREG     = 32;
    localparam int unsigned ZERO_REG = 0;

    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]   xword_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard for the integer register file.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   wb_en, wb_addr                  write-back completing this cycle (clears busy)
//   iss_valid/use1/use2/wr, ra1/ra2/iss_rd  instruction offered for issue
//   iss_ready                       combinational accept, no hazard
//   busy_cnt                        registered count of busy registers
module rf_scoreboard
    import riscv_pkg::*;
#(
    parameter int unsigned NREG = riscv_pkg::NREG,
    parameter int unsigned AW   = riscv_pkg::REG_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic          iss_valid,
    input  logic          iss_use1,
    input  logic          iss_use2,
    input  logic          iss_wr,
    input  logic [AW-1:0] iss_rd,
    output logic          iss_ready,
    output logic [AW:0]   busy_cnt
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [NREG-1:0] ebusy;
    logic [AW:0]     cnt_q, cnt_d;
    logic            hazard;

    // A write-back landing this cycle releases its register immediately.
    always_comb begin
        ebusy = '0;
        for (int i = 0; i < NREG; i++) begin
            ebusy[i] = busy_q[i] && !(wb_en && (wb_addr == AW'(i)));
        end
    end

    always_comb begin
        hazard    = (iss_use1 && ebusy[ra1]) || (iss_use2 && ebusy[ra2])
                  || (iss_wr && ebusy[iss_rd]);
        iss_ready = iss_valid && !hazard;
    end

    // Clear first, then set: a new producer on the same index keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (wb_en && (wb_addr != AW'(ZERO_REG))) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (iss_ready && iss_wr && (iss_rd != AW'(ZERO_REG))) begin
            busy_d[iss_rd] = 1'b1;
        end
        cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_d = cnt_d + (AW+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt = cnt_q;

endmodule

// File: rtl/reg_file_wb.sv
// Integer register file, write-back receiving end.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   wb_en/wb_addr/wb_data  write-back port (x0 writes discarded)
//   ra1/ra2 -> rd1/rd2     combinational reads with same-cycle write-back bypass
//   iss_*                  issue handshake checked against the busy scoreboard
//   busy_cnt               number of registers with a write-back in flight
module reg_file_wb
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = riscv_pkg::XLEN,
    parameter int unsigned NREG = riscv_pkg::NREG,
    parameter int unsigned AW   = riscv_pkg::REG_AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            iss_valid,
    input  logic            iss_use1,
    input  logic            iss_use2,
    input  logic            iss_wr,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_ready,
    output logic [AW:0]     busy_cnt
);

    logic [XLEN-1:0] regs_q [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en && (wb_addr != AW'(ZERO_REG))) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        if (ra1 == AW'(ZERO_REG))                rd1 = '0;
        else if (wb_en && (wb_addr == ra1))     rd1 = wb_data;
        else                                    rd1 = regs_q[ra1];

        if (ra2 == AW'(ZERO_REG))                rd2 = '0;
        else if (wb_en && (wb_addr == ra2))     rd2 = wb_data;
        else                                    rd2 = regs_q[ra2];
    end

    rf_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .ra1       (ra1),
        .ra2       (ra2),
        .iss_valid (iss_valid),
        .iss_use1  (iss_use1),
        .iss_use2  (iss_use2),
        .iss_wr    (iss_wr),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .busy_cnt  (busy_cnt)
    );

endmodule
